// File: rtl/wb_commit.sv
// Writeback/commit stage: selects the register-file write value, extends and aligns
// load data, owns the architectural PC and stalls execute while a load is pending.
module wb_commit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] alu_result,
  input  logic [31:0] npc_result,
  input  logic        branch_taken,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pc_out,
  output logic        commit
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t      state, state_nxt;
  logic        rf_we_nxt, commit_nxt;
  logic [4:0]  rf_waddr_nxt;
  logic [31:0] rf_wdata_nxt, pc_nxt;
  logic [4:0]  ld_rd, ld_rd_nxt;
  logic [2:0]  ld_f3, ld_f3_nxt;
  logic [1:0]  ld_off, ld_off_nxt;
  logic [31:0] ld_npc, ld_npc_nxt;
  logic [31:0] link_c;
  logic [7:0]  ld_byte_c;
  logic [15:0] ld_half_c;
  logic [31:0] ld_data_c;

  assign ex_ready = (state == IDLE);
  assign link_c   = pc_out + 32'd4;

  // Load lane selection and extension from the latched offset and width.
  always_comb begin
    ld_byte_c = mem_rdata[7:0];
    case (ld_off)
      2'd1:    ld_byte_c = mem_rdata[15:8];
      2'd2:    ld_byte_c = mem_rdata[23:16];
      2'd3:    ld_byte_c = mem_rdata[31:24];
      default: ld_byte_c = mem_rdata[7:0];
    endcase
    ld_half_c = ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_f3)
      3'b000:  ld_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
      3'b100:  ld_data_c = {24'd0, ld_byte_c};
      3'b001:  ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
      3'b101:  ld_data_c = {16'd0, ld_half_c};
      default: ld_data_c = mem_rdata;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    rf_we_nxt    = 1'b0;
    commit_nxt   = 1'b0;
    rf_waddr_nxt = rf_waddr;
    rf_wdata_nxt = rf_wdata;
    pc_nxt       = pc_out;
    ld_rd_nxt    = ld_rd;
    ld_f3_nxt    = ld_f3;
    ld_off_nxt   = ld_off;
    ld_npc_nxt   = ld_npc;
    case (state)
      IDLE: begin
        if (ex_valid) begin
          if (opcode == OP_LOAD) begin
            ld_rd_nxt  = rd_addr;
            ld_f3_nxt  = funct3;
            ld_off_nxt = alu_result[1:0];
            ld_npc_nxt = npc_result;
            state_nxt  = WAIT_LOAD;
          end else begin
            commit_nxt = 1'b1;
            pc_nxt     = npc_result;
            case (opcode)
              OP_LUI, OP_AUIPC, OP_OPIMM, OP_OP: begin
                rf_we_nxt    = (rd_addr != 5'd0);
                rf_waddr_nxt = rd_addr;
                rf_wdata_nxt = alu_result;
              end
              OP_JAL: begin
                rf_we_nxt    = (rd_addr != 5'd0);
                rf_waddr_nxt = rd_addr;
                rf_wdata_nxt = link_c;
              end
              OP_JALR: begin
                rf_we_nxt    = (rd_addr != 5'd0);
                rf_waddr_nxt = rd_addr;
                rf_wdata_nxt = link_c;
                pc_nxt       = {npc_result[31:1], 1'b0};
              end
              OP_BRANCH: pc_nxt = branch_taken ? npc_result : link_c;
              default: ;
            endcase
          end
        end
      end
      WAIT_LOAD: begin
        if (mem_rvalid) begin
          rf_we_nxt    = (ld_rd != 5'd0);
          rf_waddr_nxt = ld_rd;
          rf_wdata_nxt = ld_data_c;
          pc_nxt       = ld_npc;
          commit_nxt   = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
      pc_out   <= RESET_PC;
      commit   <= 1'b0;
      ld_rd    <= 5'd0;
      ld_f3    <= 3'd0;
      ld_off   <= 2'd0;
      ld_npc   <= 32'd0;
    end else begin
      state    <= state_nxt;
      rf_we    <= rf_we_nxt;
      rf_waddr <= rf_waddr_nxt;
      rf_wdata <= rf_wdata_nxt;
      pc_out   <= pc_nxt;
      commit   <= commit_nxt;
      ld_rd    <= ld_rd_nxt;
      ld_f3    <= ld_f3_nxt;
      ld_off   <= ld_off_nxt;
      ld_npc   <= ld_npc_nxt;
    end
  end

endmodule
